mem_stage_lsu: RTL

Load/store unit forming the MEM pipeline stage directly upstream of the word-addressed data memory (combinational read, clocked word write, word index = address[22:2]).
- Takes EX/MEM register contents and drives the memory address, write enable and write data.
- Extracts and sign/zero-extends byte/halfword loads.
- Implements byte/halfword stores as a 2-cycle read-modify-write with a pipeline stall.
- Registers results into the MEM/WB boundary.

---
 rtl/mem_stage_lsu_if.sv | 42 ++++
 rtl/mem_stage_lsu.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// EX/MEM inputs, data-memory port and MEM/WB outputs of the MEM-stage load/store unit.
// The master modport is the LSU's view; slave is the surrounding pipeline and memory.
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 4
);
  logic              ex_valid;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [1:0]        ex_size;
  logic              ex_signed;
  logic [ADDR_W-1:0] ex_addr;
  logic [31:0]       ex_wdata;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_reg_write;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_we;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  logic              stall;
  logic              wb_valid;
  logic              wb_reg_write;
  logic [REG_W-1:0]  wb_rd;
  logic [31:0]       wb_data;
  logic              misalign_fault;

  modport master (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_size, ex_signed,
           ex_addr, ex_wdata, ex_rd, ex_reg_write, mem_read_data,
    output mem_address, mem_we, mem_write_data, stall,
           wb_valid, wb_reg_write, wb_rd, wb_data, misalign_fault
  );

  modport slave (
    output ex_valid, ex_mem_read, ex_mem_write, ex_size, ex_signed,
           ex_addr, ex_wdata, ex_rd, ex_reg_write, mem_read_data,
    input  mem_address, mem_we, mem_write_data, stall,
           wb_valid, wb_reg_write, wb_rd, wb_data, misalign_fault
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: sub-word load extraction, read-modify-write sub-word stores
// with a one-cycle stall, and the MEM/WB pipeline register.
module mem_stage_lsu #(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 4
) (
  input logic clk,
  input logic reset,
  mem_stage_lsu_if.master bus
);

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_RMW_WRITE = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] merge_r;
  logic [31:0] merge_nxt_s;

  logic [1:0]  lane_s;
  logic        size_half_s;
  logic        size_word_s;
  logic        fault_s;
  logic        store_s;
  logic        sub_store_s;
  logic        load_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] load_data_s;
  logic [31:0] merged_s;
  logic [31:0] wb_data_nxt_s;
  logic        stall_s;
  logic        mem_we_s;
  logic [31:0] mem_wdata_s;

  assign bus.mem_address    = bus.ex_addr;
  assign bus.stall          = stall_s;
  assign bus.mem_we         = mem_we_s;
  assign bus.mem_write_data = mem_wdata_s;

  // Decode access kind, alignment and the load/merge data paths.
  always_comb begin
    lane_s      = bus.ex_addr[1:0];
    size_half_s = (bus.ex_size == 2'b01);
    size_word_s = bus.ex_size[1];
    fault_s     = bus.ex_valid & (bus.ex_mem_read | bus.ex_mem_write) &
                  ((size_half_s & lane_s[0]) | (size_word_s & (lane_s != 2'b00)));
    store_s     = bus.ex_valid & bus.ex_mem_write & ~fault_s;
    sub_store_s = store_s & ~size_word_s;
    load_s      = bus.ex_valid & bus.ex_mem_read & ~bus.ex_mem_write & ~fault_s;

    case (lane_s)
      2'b00:   byte_s = bus.mem_read_data[7:0];
      2'b01:   byte_s = bus.mem_read_data[15:8];
      2'b10:   byte_s = bus.mem_read_data[23:16];
      2'b11:   byte_s = bus.mem_read_data[31:24];
      default: byte_s = 8'h00;
    endcase
    if (lane_s[1]) begin
      half_s = bus.mem_read_data[31:16];
    end else begin
      half_s = bus.mem_read_data[15:0];
    end

    case (bus.ex_size)
      2'b00:   load_data_s = {{24{bus.ex_signed & byte_s[7]}}, byte_s};
      2'b01:   load_data_s = {{16{bus.ex_signed & half_s[15]}}, half_s};
      default: load_data_s = bus.mem_read_data;
    endcase

    // Old word with only the addressed lane(s) replaced by the store data.
    merged_s = bus.mem_read_data;
    if (size_half_s) begin
      if (lane_s[1]) begin
        merged_s[31:16] = bus.ex_wdata[15:0];
      end else begin
        merged_s[15:0] = bus.ex_wdata[15:0];
      end
    end else begin
      case (lane_s)
        2'b00:   merged_s[7:0]   = bus.ex_wdata[7:0];
        2'b01:   merged_s[15:8]  = bus.ex_wdata[7:0];
        2'b10:   merged_s[23:16] = bus.ex_wdata[7:0];
        2'b11:   merged_s[31:24] = bus.ex_wdata[7:0];
        default: merged_s        = bus.mem_read_data;
      endcase
    end

    if (fault_s) begin
      wb_data_nxt_s = 32'h0000_0000;
    end else if (load_s) begin
      wb_data_nxt_s = load_data_s;
    end else begin
      wb_data_nxt_s = 32'(bus.ex_addr);
    end
  end

  // Next-state and memory-port control for the read-modify-write sequence.
  always_comb begin
    state_nxt_s = state_r;
    merge_nxt_s = merge_r;
    stall_s     = 1'b0;
    mem_we_s    = 1'b0;
    mem_wdata_s = bus.ex_wdata;
    case (state_r)
      ST_IDLE: begin
        if (sub_store_s) begin
          stall_s     = 1'b1;
          merge_nxt_s = merged_s;
          state_nxt_s = ST_RMW_WRITE;
        end else begin
          mem_we_s = store_s & ~reset;
        end
      end
      ST_RMW_WRITE: begin
        mem_we_s    = ~reset;
        mem_wdata_s = merge_r;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and merge buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      merge_r <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      merge_r <= merge_nxt_s;
    end
  end

  // MEM/WB register: bubble on the stall cycle, store completion on the write cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.wb_valid       <= 1'b0;
      bus.wb_reg_write   <= 1'b0;
      bus.wb_rd          <= {REG_W{1'b0}};
      bus.wb_data        <= 32'h0000_0000;
      bus.misalign_fault <= 1'b0;
    end else if (stall_s) begin
      bus.wb_valid       <= 1'b0;
      bus.wb_reg_write   <= 1'b0;
      bus.misalign_fault <= 1'b0;
    end else if (state_r == ST_RMW_WRITE) begin
      bus.wb_valid       <= 1'b1;
      bus.wb_reg_write   <= 1'b0;
      bus.wb_rd          <= bus.ex_rd;
      bus.wb_data        <= wb_data_nxt_s;
      bus.misalign_fault <= 1'b0;
    end else begin
      bus.wb_valid       <= bus.ex_valid;
      bus.wb_reg_write   <= bus.ex_valid & bus.ex_reg_write & ~fault_s;
      bus.wb_rd          <= bus.ex_rd;
      bus.wb_data        <= wb_data_nxt_s;
      bus.misalign_fault <= fault_s;
    end
  end

endmodule
